// File: rtl/clk_rate_gen_if.sv
// Divisor-load bus for clk_rate_gen.
//   LD_EN   master->slave  one-cycle load strobe
//   LD_CH   master->slave  target channel index (CH_W bits)
//   LD_VAL  master->slave  new divisor (CNT_W bits)
//   LD_ACK  slave->master  one-cycle acknowledge, the cycle after an accepted load
interface clk_rate_gen_if #(
   parameter int unsigned CH_W  = 2,
   parameter int unsigned CNT_W = 24
);
   logic             LD_EN;
   logic [CH_W-1:0]  LD_CH;
   logic [CNT_W-1:0] LD_VAL;
   logic             LD_ACK;

   modport master (output LD_EN, output LD_CH, output LD_VAL, input LD_ACK);
   modport slave  (input LD_EN, input LD_CH, input LD_VAL, output LD_ACK);
endinterface

// File: rtl/clk_rate_gen.sv
// Multi-channel programmable clock divider / rate generator.
// Each channel counts 0..div and, on reaching div, wraps to 0, toggles its
// CLKOUT and raises TICK for one cycle (tick period div+1, CLKOUT period
// 2*(div+1)). Divisors load at runtime over the ld bus; SYNC realigns all
// channels; EN freezes channels individually.
// Ports:
//   CLK     system clock, posedge
//   RST     synchronous active-high reset
//   EN      per-channel run enable (0 = freeze count and CLKOUT)
//   SYNC    one-cycle pulse: clear all counts, CLKOUT and TICK
//   ld      divisor load bus (slave side): LD_EN/LD_CH/LD_VAL in, LD_ACK out
//   CLKOUT  per-channel 50% toggle clock
//   TICK    per-channel one-cycle strobe, coincident with each CLKOUT edge
module clk_rate_gen #(
   parameter int unsigned      NUM_CH      = 4,
   parameter int unsigned      CNT_W       = 24,
   parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(24'h989680)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] EN,
   input  logic              SYNC,
   clk_rate_gen_if.slave     ld,
   output logic [NUM_CH-1:0] CLKOUT,
   output logic [NUM_CH-1:0] TICK
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   // One bit wider than LD_CH so NUM_CH itself is representable.
   localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);

   logic [CNT_W-1:0]  count [NUM_CH];
   logic [CNT_W-1:0]  div   [NUM_CH];
   logic              ld_ok;
   logic [NUM_CH-1:0] ld_hit;
   logic              ack_q;

   assign ld_ok     = ld.LD_EN && ({1'b0, ld.LD_CH} < CH_LIMIT);
   assign ld.LD_ACK = ack_q;

   always_comb begin
      ld_hit = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ld_ok && (ld.LD_CH == CH_W'(i))) begin
            ld_hit[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ack_q  <= 1'b0;
         CLKOUT <= '0;
         TICK   <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            count[i] <= '0;
            div[i]   <= DIV_DEFAULT;
         end
      end else begin
         ack_q <= ld_ok;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ld_hit[i]) begin
               div[i] <= ld.LD_VAL;
            end
            // SYNC outranks a same-cycle load for the phase state; the
            // divisor write above still lands.
            if (SYNC) begin
               count[i]  <= '0;
               CLKOUT[i] <= 1'b0;
               TICK[i]   <= 1'b0;
            end else if (ld_hit[i]) begin
               count[i] <= '0;
               TICK[i]  <= 1'b0;
            end else if (EN[i]) begin
               if (count[i] == div[i]) begin
                  count[i]  <= '0;
                  CLKOUT[i] <= ~CLKOUT[i];
                  TICK[i]   <= 1'b1;
               end else begin
                  count[i] <= count[i] + CNT_W'(1);
                  TICK[i]  <= 1'b0;
               end
            end else begin
               TICK[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_rate_gen.sv
// Self-checking bench for clk_rate_gen (5 channels so that out-of-range
// channel indices are expressible, DIV_DEFAULT = 4).
// Reference model: per channel, the number of running cycles p since the
// last realignment and the CLKOUT level b at that realignment; TICK fires
// when p is a nonzero multiple of div+1 and CLKOUT = b xor parity(p/(div+1)).
module tb_clk_rate_gen;

   localparam int unsigned NUM_CH = 5;
   localparam int unsigned CNT_W  = 24;
   localparam int unsigned CH_W   = 3;
   localparam int unsigned DIV    = 4;

   logic              CLK;
   logic              RST;
   logic [NUM_CH-1:0] EN;
   logic              SYNC;
   logic [NUM_CH-1:0] CLKOUT;
   logic [NUM_CH-1:0] TICK;

   clk_rate_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) ld_bus ();

   clk_rate_gen #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .DIV_DEFAULT(CNT_W'(DIV))
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .SYNC  (SYNC),
      .ld    (ld_bus),
      .CLKOUT(CLKOUT),
      .TICK  (TICK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned total = 0;
   int unsigned bad   = 0;

   int unsigned       m_p   [NUM_CH];
   int unsigned       m_div [NUM_CH];
   logic [NUM_CH-1:0] m_base;
   logic [NUM_CH-1:0] m_clk;
   logic [NUM_CH-1:0] m_tick;
   logic              m_ack;

   task automatic model_edge();
      bit ok;
      bit hit;
      if (RST === 1'b1) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_p[i]   = 0;
            m_div[i] = DIV;
         end
         m_base = '0; m_clk = '0; m_tick = '0; m_ack = 1'b0;
         return;
      end
      ok    = (ld_bus.LD_EN === 1'b1) && (int'(ld_bus.LD_CH) < NUM_CH);
      m_ack = ok;
      for (int i = 0; i < NUM_CH; i++) begin
         hit = ok && (int'(ld_bus.LD_CH) == i);
         if (hit) m_div[i] = int'(ld_bus.LD_VAL);
         if (SYNC) begin
            m_p[i] = 0; m_base[i] = 1'b0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
         end else if (hit) begin
            m_p[i] = 0; m_base[i] = m_clk[i]; m_tick[i] = 1'b0;
         end else if (EN[i]) begin
            m_p[i]++;
            m_tick[i] = ((m_p[i] % (m_div[i] + 1)) == 0);
            m_clk[i]  = m_base[i] ^ (((m_p[i] / (m_div[i] + 1)) % 2) == 1);
         end else begin
            m_tick[i] = 1'b0;
         end
      end
   endtask

   // One clock edge: advance the model with the inputs present at the edge,
   // then leave time 1 unit past the edge for sampling.
   task automatic cyc();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      int unsigned first;
      RST = 1'b1; EN = '1; SYNC = 1'b0;
      ld_bus.LD_EN = 1'b0; ld_bus.LD_CH = '0; ld_bus.LD_VAL = '0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         total++;
         if (CLKOUT !== '0 || TICK !== '0 || ld_bus.LD_ACK !== 1'b0) begin
            bad++;
            $display("FAIL reset_state clkout=%b tick=%b ack=%b required all 0", CLKOUT, TICK, ld_bus.LD_ACK);
         end
      end
      RST = 1'b0;
      first = 0;
      for (int k = 1; k <= 20 && first == 0; k++) begin
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL reset_run tick=%b clkout=%b required tick=%b clkout=%b", TICK, CLKOUT, m_tick, m_clk);
         end
         if (TICK[0] === 1'b1) first = k;
      end
      total++;
      if (first != DIV + 1) begin
         bad++;
         $display("FAIL first_tick cycles=%0d required %0d", first, DIV + 1);
      end
   endtask

   task automatic test_rate();
      int unsigned ticks0;
      int unsigned high0;
      ticks0 = 0; high0 = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL rate_model tick=%b clkout=%b required tick=%b clkout=%b", TICK, CLKOUT, m_tick, m_clk);
         end
         total++;
         if ((TICK !== '0 && TICK !== '1) || (CLKOUT !== '0 && CLKOUT !== '1)) begin
            bad++;
            $display("FAIL rate_phase tick=%b clkout=%b required all channels equal", TICK, CLKOUT);
         end
         if (TICK[0] === 1'b1) ticks0++;
         if (CLKOUT[0] === 1'b1) high0++;
      end
      total++;
      if (ticks0 != 4 || high0 != 10) begin
         bad++;
         $display("FAIL rate_count ticks=%0d high=%0d required ticks=4 high=10", ticks0, high0);
      end
   endtask

   task automatic test_load();
      logic        prev1;
      int unsigned ticks0;
      ld_bus.LD_EN = 1'b1; ld_bus.LD_CH = 3'd1; ld_bus.LD_VAL = '0;
      cyc();
      ld_bus.LD_EN = 1'b0;
      total++;
      if (ld_bus.LD_ACK !== 1'b1 || TICK[1] !== 1'b0) begin
         bad++;
         $display("FAIL load_ack ack=%b tick1=%b required ack=1 tick1=0", ld_bus.LD_ACK, TICK[1]);
      end
      prev1  = CLKOUT[1];
      ticks0 = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk || ld_bus.LD_ACK !== m_ack) begin
            bad++;
            $display("FAIL load_model tick=%b clkout=%b ack=%b required %b %b %b", TICK, CLKOUT, ld_bus.LD_ACK, m_tick, m_clk, m_ack);
         end
         total++;
         if (TICK[1] !== 1'b1 || CLKOUT[1] !== ~prev1 || (k == 0 && ld_bus.LD_ACK !== 1'b0)) begin
            bad++;
            $display("FAIL load_div0 tick1=%b clkout1=%b ack=%b required tick1=1 clkout1=%b", TICK[1], CLKOUT[1], ld_bus.LD_ACK, ~prev1);
         end
         prev1 = CLKOUT[1];
         if (TICK[0] === 1'b1) ticks0++;
      end
      total++;
      if (ticks0 != 2) begin
         bad++;
         $display("FAIL load_ch0_period ticks=%0d required 2", ticks0);
      end
   endtask

   task automatic test_freeze();
      logic        held;
      int unsigned resume;
      for (int k = 0; k < 10 && (m_p[0] % (m_div[0] + 1)) != 2; k++) cyc();
      EN[0] = 1'b0;
      held  = CLKOUT[0];
      for (int k = 0; k < 7; k++) begin
         cyc();
         total++;
         if (TICK[0] !== 1'b0 || CLKOUT[0] !== held || TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL freeze_hold tick=%b clkout=%b required tick=%b clkout=%b", TICK, CLKOUT, m_tick, m_clk);
         end
      end
      EN[0]  = 1'b1;
      resume = 0;
      for (int k = 1; k <= 12 && resume == 0; k++) begin
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL freeze_model tick=%b clkout=%b required tick=%b clkout=%b", TICK, CLKOUT, m_tick, m_clk);
         end
         if (TICK[0] === 1'b1) resume = k;
      end
      total++;
      if (resume != 3) begin
         bad++;
         $display("FAIL freeze_resume cycles=%0d required 3", resume);
      end
   endtask

   task automatic test_sync_bounds();
      int unsigned divs [4] = '{4, 4, 2, 7};
      int unsigned first;
      for (int c = 0; c < 4; c++) begin
         ld_bus.LD_EN = 1'b1; ld_bus.LD_CH = CH_W'(c); ld_bus.LD_VAL = CNT_W'(divs[c]);
         cyc();
      end
      ld_bus.LD_EN = 1'b0;
      for (int k = 0; k < 13 + int'($urandom_range(0, 9)); k++) begin
         EN = NUM_CH'($urandom);
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk || ld_bus.LD_ACK !== m_ack) begin
            bad++;
            $display("FAIL mixed_model tick=%b clkout=%b ack=%b required %b %b %b", TICK, CLKOUT, ld_bus.LD_ACK, m_tick, m_clk, m_ack);
         end
      end
      EN = '1; SYNC = 1'b1;
      cyc();
      SYNC = 1'b0;
      total++;
      if (CLKOUT !== '0 || TICK !== '0) begin
         bad++;
         $display("FAIL sync_clear clkout=%b tick=%b required all 0", CLKOUT, TICK);
      end
      first = 0;
      for (int k = 1; k <= 12 && first == 0; k++) begin
         cyc();
         total++;
         if (TICK[0] !== TICK[1] || TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL sync_align tick=%b clkout=%b required tick=%b clkout=%b", TICK, CLKOUT, m_tick, m_clk);
         end
         if (TICK[0] === 1'b1) first = k;
      end
      total++;
      if (first != 5) begin
         bad++;
         $display("FAIL sync_first_tick cycles=%0d required 5", first);
      end
      ld_bus.LD_EN = 1'b1; ld_bus.LD_CH = CH_W'(NUM_CH); ld_bus.LD_VAL = CNT_W'(1);
      cyc();
      ld_bus.LD_CH = 3'd7;
      cyc();
      ld_bus.LD_EN = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         total++;
         if (ld_bus.LD_ACK !== 1'b0 || TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL bad_ch ack=%b tick=%b clkout=%b required ack=0 tick=%b clkout=%b", ld_bus.LD_ACK, TICK, CLKOUT, m_tick, m_clk);
         end
      end
   endtask

   task automatic test_corner();
      int unsigned t1;
      int unsigned t2;
      cyc(); cyc(); cyc();
      ld_bus.LD_EN = 1'b1; ld_bus.LD_CH = 3'd2; ld_bus.LD_VAL = CNT_W'(3); SYNC = 1'b1;
      cyc();
      ld_bus.LD_EN = 1'b0; SYNC = 1'b0;
      total++;
      if (ld_bus.LD_ACK !== 1'b1 || CLKOUT !== '0 || TICK !== '0) begin
         bad++;
         $display("FAIL sync_load ack=%b clkout=%b tick=%b required ack=1 clkout=0 tick=0", ld_bus.LD_ACK, CLKOUT, TICK);
      end
      t1 = 0; t2 = 0;
      for (int k = 1; k <= 12 && t2 == 0; k++) begin
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk || ld_bus.LD_ACK !== m_ack) begin
            bad++;
            $display("FAIL sync_load_model tick=%b clkout=%b ack=%b required %b %b %b", TICK, CLKOUT, ld_bus.LD_ACK, m_tick, m_clk, m_ack);
         end
         if (TICK[2] === 1'b1) begin
            if (t1 == 0) t1 = k;
            else t2 = k;
         end
      end
      total++;
      if (t1 != 4 || t2 != 8) begin
         bad++;
         $display("FAIL ch2_period ticks_at=%0d,%0d required 4,8", t1, t2);
      end
      cyc(); cyc();
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      total++;
      if (CLKOUT !== '0 || TICK !== '0 || ld_bus.LD_ACK !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset clkout=%b tick=%b ack=%b required all 0", CLKOUT, TICK, ld_bus.LD_ACK);
      end
      t1 = 0;
      for (int k = 1; k <= 12 && t1 == 0; k++) begin
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk) begin
            bad++;
            $display("FAIL mid_reset_model tick=%b clkout=%b required tick=%b clkout=%b", TICK, CLKOUT, m_tick, m_clk);
         end
         if (TICK[0] === 1'b1) t1 = k;
      end
      total++;
      if (t1 != DIV + 1 || TICK !== '1) begin
         bad++;
         $display("FAIL mid_reset_defaults first=%0d tick=%b required first=%0d tick=all 1", t1, TICK, DIV + 1);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         EN            = NUM_CH'($urandom);
         SYNC          = ($urandom_range(0, 22) == 0);
         RST           = ($urandom_range(0, 96) == 0);
         ld_bus.LD_EN  = ($urandom_range(0, 4) == 0);
         ld_bus.LD_CH  = CH_W'($urandom_range(0, 7));
         ld_bus.LD_VAL = CNT_W'($urandom_range(0, 9));
         cyc();
         total++;
         if (TICK !== m_tick || CLKOUT !== m_clk || ld_bus.LD_ACK !== m_ack) begin
            bad++;
            $display("FAIL random_model cyc=%0d tick=%b clkout=%b ack=%b required %b %b %b", k, TICK, CLKOUT, ld_bus.LD_ACK, m_tick, m_clk, m_ack);
         end
      end
      RST = 1'b0; SYNC = 1'b0; ld_bus.LD_EN = 1'b0; EN = '1;
   endtask

   initial begin
      test_reset();
      test_rate();
      test_load();
      test_freeze();
      test_sync_bounds();
      test_corner();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
